// File: rtl/imem_fetch_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
package imem_fetch_pkg;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  localparam int unsigned DEFAULT_RESET_PC = 0;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: load captures a fetched word, squash only clears
// the valid bit, neither asserted holds everything.
module ifid_reg #(
  parameter int unsigned DWL = 32,
  parameter int unsigned AWL = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           squash,
  input  logic [DWL-1:0] instr_in,
  input  logic [AWL-1:0] pc_in,
  output logic [DWL-1:0] instr,
  output logic [AWL-1:0] pc,
  output logic           valid
);

  logic [DWL-1:0] instr_q, instr_d;
  logic [AWL-1:0] pc_q, pc_d;
  logic           valid_q, valid_d;

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (squash) begin
      valid_d = 1'b0;
    end else if (load) begin
      instr_d = instr_in;
      pc_d    = pc_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign instr = instr_q;
  assign pc    = pc_q;
  assign valid = valid_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the PC, feeds IF/ID, and shares the imem port with a
// debugger while halted.
module imem_fetch_ctrl
  import imem_fetch_pkg::*;
#(
  parameter int unsigned    DWL      = 32,
  parameter int unsigned    AWL      = 5,
  parameter logic [AWL-1:0] RESET_PC = AWL'(DEFAULT_RESET_PC)
) (
  input  logic           CLK,
  input  logic           RST,
  output logic [AWL-1:0] IMA,
  input  logic [DWL-1:0] IMRD,
  input  logic           STALL,
  input  logic           FLUSH,
  input  logic           REDIR,
  input  logic [AWL-1:0] REDIR_PC,
  input  logic           HALT_REQ,
  input  logic           RESUME,
  input  logic           DBG_REQ,
  input  logic [AWL-1:0] DBG_ADDR,
  output logic           DBG_ACK,
  output logic [DWL-1:0] DBG_DATA,
  output logic [DWL-1:0] IFID_INSTR,
  output logic [AWL-1:0] IFID_PC,
  output logic           IFID_VALID,
  output logic           HALTED,
  output logic [31:0]    FETCH_CNT
);

  fetch_state_e   state_q, state_d;
  logic [AWL-1:0] pc_q, pc_d;
  logic [31:0]    cnt_q, cnt_d;
  logic           ack_q, ack_d;
  logic [DWL-1:0] data_q, data_d;
  logic           ifid_load, ifid_squash;
  logic           in_halt;

  assign in_halt = (state_q == ST_HALT);
  assign IMA     = (in_halt && DBG_REQ) ? DBG_ADDR : pc_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    ack_d       = 1'b0;
    data_d      = data_q;
    ifid_load   = 1'b0;
    ifid_squash = 1'b0;
    if (!in_halt) begin
      if (REDIR) begin
        pc_d        = REDIR_PC;
        ifid_squash = 1'b1;
      end else if (FLUSH) begin
        ifid_squash = 1'b1;
      end else if (!STALL) begin
        pc_d      = pc_q + AWL'(1);
        ifid_load = 1'b1;
      end
      // A halt keeps the PC step chosen above but discards the word fetched
      // on this edge, so it is neither loaded nor counted.
      if (HALT_REQ) begin
        state_d     = ST_HALT;
        ifid_load   = 1'b0;
        ifid_squash = 1'b1;
      end
      if (ifid_load) begin
        cnt_d = cnt_q + 32'd1;
      end
    end else begin
      ack_d = DBG_REQ;
      if (DBG_REQ) begin
        data_d = IMRD;
      end
      if (RESUME) begin
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
    end
  end

  ifid_reg #(
    .DWL (DWL),
    .AWL (AWL)
  ) u_ifid_reg (
    .clk      (CLK),
    .rst      (RST),
    .load     (ifid_load),
    .squash   (ifid_squash),
    .instr_in (IMRD),
    .pc_in    (pc_q),
    .instr    (IFID_INSTR),
    .pc       (IFID_PC),
    .valid    (IFID_VALID)
  );

  assign DBG_ACK   = ack_q;
  assign DBG_DATA  = data_q;
  assign HALTED    = in_halt;
  assign FETCH_CNT = cnt_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a cycle model of the fetch rules.
module tb_imem_fetch_ctrl;

  localparam int DWL = 32;
  localparam int AWL = 5;
  localparam int NW  = 32;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic [AWL-1:0] IMA;
  logic [DWL-1:0] IMRD;
  logic           STALL = 1'b0, FLUSH = 1'b0, REDIR = 1'b0;
  logic [AWL-1:0] REDIR_PC = '0;
  logic           HALT_REQ = 1'b0, RESUME = 1'b0, DBG_REQ = 1'b0;
  logic [AWL-1:0] DBG_ADDR = '0;
  logic           DBG_ACK;
  logic [DWL-1:0] DBG_DATA;
  logic [DWL-1:0] IFID_INSTR;
  logic [AWL-1:0] IFID_PC;
  logic           IFID_VALID;
  logic           HALTED;
  logic [31:0]    FETCH_CNT;

  logic [DWL-1:0] rom [0:NW-1];

  initial begin
    for (int i = 0; i < NW; i++) rom[i] = 32'h100 + i;
  end
  assign IMRD = rom[IMA];

  imem_fetch_ctrl #(.DWL(DWL), .AWL(AWL), .RESET_PC(5'd0)) dut (
    .CLK(CLK), .RST(RST), .IMA(IMA), .IMRD(IMRD),
    .STALL(STALL), .FLUSH(FLUSH), .REDIR(REDIR), .REDIR_PC(REDIR_PC),
    .HALT_REQ(HALT_REQ), .RESUME(RESUME), .DBG_REQ(DBG_REQ), .DBG_ADDR(DBG_ADDR),
    .DBG_ACK(DBG_ACK), .DBG_DATA(DBG_DATA), .IFID_INSTR(IFID_INSTR),
    .IFID_PC(IFID_PC), .IFID_VALID(IFID_VALID), .HALTED(HALTED), .FETCH_CNT(FETCH_CNT)
  );

  always #5 CLK = ~CLK;

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: architectural state updated once per rising edge.
  int  m_pc = 0, m_cnt = 0, m_ifpc = 0;
  bit  m_halt = 0, m_valid = 0, m_ack = 0, started = 0;
  logic [31:0] m_instr = 0, m_data = 0;

  always @(posedge CLK) begin
    started = 1;
    if (RST) begin
      m_pc = 0; m_cnt = 0; m_halt = 0; m_valid = 0; m_ack = 0;
      m_data = 0; m_instr = 0; m_ifpc = 0;
    end else if (!m_halt) begin
      m_ack = 0;
      if (REDIR) begin
        m_pc = int'(REDIR_PC);
        m_valid = 0;
      end else if (FLUSH) begin
        m_valid = 0;
      end else if (!STALL) begin
        if (!HALT_REQ) begin
          m_instr = rom[m_pc];
          m_ifpc  = m_pc;
          m_valid = 1;
          m_cnt   = m_cnt + 1;
        end
        m_pc = (m_pc + 1) % NW;
      end
      if (HALT_REQ) begin
        m_halt  = 1;
        m_valid = 0;
      end
    end else begin
      m_ack = DBG_REQ;
      if (DBG_REQ) m_data = rom[int'(DBG_ADDR)];
      if (RESUME) m_halt = 0;
    end
  end

  always @(negedge CLK) begin
    if (started) begin
      chk("m_valid", 32'(IFID_VALID), 32'(m_valid));
      chk("m_halted", 32'(HALTED), 32'(m_halt));
      chk("m_ack", 32'(DBG_ACK), 32'(m_ack));
      chk("m_dbg_data", DBG_DATA, m_data);
      chk("m_fetch_cnt", FETCH_CNT, 32'(m_cnt));
      chk("m_ima", 32'(IMA), (m_halt && DBG_REQ) ? 32'(DBG_ADDR) : 32'(m_pc));
      if (m_valid) begin
        chk("m_ifid_instr", IFID_INSTR, m_instr);
        chk("m_ifid_pc", 32'(IFID_PC), 32'(m_ifpc));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
      $display("t=%0t ima=%0d ifid_pc=%0d instr=0x%0h v=%0b halted=%0b ack=%0b dbg=0x%0h cnt=%0d",
               $time, IMA, IFID_PC, IFID_INSTR, IFID_VALID, HALTED, DBG_ACK, DBG_DATA, FETCH_CNT);
    end
  endtask

  task automatic clr();
    STALL = 0; FLUSH = 0; REDIR = 0; HALT_REQ = 0; RESUME = 0; DBG_REQ = 0;
  endtask

  initial begin
    RST = 1; step(2);
    RST = 0;
    chk("rst_valid", 32'(IFID_VALID), 0);
    chk("rst_halted", 32'(HALTED), 0);
    chk("rst_cnt", FETCH_CNT, 0);
    chk("rst_ima", 32'(IMA), 0);
    chk("rst_ack", 32'(DBG_ACK), 0);
    chk("rst_dbg_data", DBG_DATA, 0);

    step(1);
    chk("first_instr", IFID_INSTR, 32'h100);
    chk("first_pc", 32'(IFID_PC), 0);
    step(3);
    chk("run4_instr", IFID_INSTR, 32'h103);
    chk("run4_pc", 32'(IFID_PC), 3);
    chk("run4_cnt", FETCH_CNT, 4);

    STALL = 1; step(2);
    chk("stall_instr", IFID_INSTR, 32'h103);
    chk("stall_cnt", FETCH_CNT, 4);
    REDIR = 1; REDIR_PC = 5'd20; step(1);
    clr();
    chk("redir_bubble", 32'(IFID_VALID), 0);
    step(1);
    chk("redir_instr", IFID_INSTR, 32'h114);
    chk("redir_pc", 32'(IFID_PC), 20);

    REDIR = 1; REDIR_PC = 5'd4; step(1);
    clr(); step(1);
    FLUSH = 1; step(1);
    clr();
    chk("flush_valid", 32'(IFID_VALID), 0);
    step(1);
    chk("refetch_pc", 32'(IFID_PC), 5);
    chk("refetch_cnt", FETCH_CNT, 7);
    step(1);

    HALT_REQ = 1; STALL = 1; step(1);
    clr();
    chk("halted", 32'(HALTED), 1);
    chk("halt_ima", 32'(IMA), 7);
    DBG_REQ = 1; DBG_ADDR = 5'd2; #1;
    chk("dbg_ima", 32'(IMA), 2);
    step(1);
    chk("dbg0_data", DBG_DATA, 32'h102);
    DBG_ADDR = 5'd30; step(1);
    chk("dbg1_data", DBG_DATA, 32'h11e);
    chk("dbg1_ack", 32'(DBG_ACK), 1);
    DBG_ADDR = 5'd31; step(1);
    chk("dbg2_data", DBG_DATA, 32'h11f);
    clr(); REDIR = 1; REDIR_PC = 5'd9; FLUSH = 1; step(1);
    chk("halt_ignores_redir", 32'(IMA), 7);
    chk("ack_drops", 32'(DBG_ACK), 0);
    clr(); RESUME = 1; HALT_REQ = 1; DBG_REQ = 1; DBG_ADDR = 5'd3; step(1);
    clr();
    chk("resume_halted", 32'(HALTED), 0);
    chk("resume_dbg_data", DBG_DATA, 32'h103);
    step(1);
    chk("resume_pc", 32'(IFID_PC), 7);
    chk("resume_valid", 32'(IFID_VALID), 1);

    DBG_REQ = 1; DBG_ADDR = 5'd1; step(1);
    clr();
    chk("run_dbg_no_ack", 32'(DBG_ACK), 0);

    REDIR = 1; REDIR_PC = 5'd31; step(1);
    clr(); step(1);
    chk("wrap_pc31", 32'(IFID_PC), 31);
    step(1);
    chk("wrap_pc0", 32'(IFID_PC), 0);
    chk("wrap_instr", IFID_INSTR, 32'h100);
    chk("wrap_cnt", FETCH_CNT, 12);

    HALT_REQ = 1; FLUSH = 1; step(1);
    clr(); DBG_REQ = 1; DBG_ADDR = 5'd5; step(1);
    chk("pre_rst_ack", 32'(DBG_ACK), 1);
    RST = 1; step(1);
    chk("rst_halt_halted", 32'(HALTED), 0);
    chk("rst_halt_ack", 32'(DBG_ACK), 0);
    chk("rst_halt_cnt", FETCH_CNT, 0);
    chk("rst_halt_ima", 32'(IMA), 0);
    RST = 0; clr(); step(1);
    chk("post_rst_pc", 32'(IFID_PC), 0);
    chk("post_rst_cnt", FETCH_CNT, 1);
    step(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Instruction-fetch sequencer for the 5-stage pipeline. Owns the program counter, drives the instruction-memory read address, and loads the IF/ID pipeline register. Applies stall, flush and branch/jump redirects from the hazard and execute stages. Provides a debug halt mode in which an external debugger can read instruction memory through the same port.

## Interface
Parameters:
- DWL, 32, instruction word width
- AWL, 5, instruction-memory word-address width; the PC is a word index
- RESET_PC, 0, PC value loaded on reset (AWL bits)

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  synchronous, active-high reset
- IMA  out  AWL  instruction-memory read address (combinational)
- IMRD  in  DWL  instruction-memory read data; combinational from IMA
- STALL  in  1  hold PC and IF/ID
- FLUSH  in  1  squash IF/ID contents
- REDIR  in  1  taken branch/jump
- REDIR_PC  in  AWL  redirect target
- HALT_REQ  in  1  debug halt request
- RESUME  in  1  leave halt
- DBG_REQ  in  1  debug read request; honoured only while halted
- DBG_ADDR  in  AWL  debug read address
- DBG_ACK  out  1  one-cycle pulse; DBG_DATA is valid
- DBG_DATA  out  DWL  debug read data
- IFID_INSTR  out  DWL  fetched instruction
- IFID_PC  out  AWL  PC of IFID_INSTR
- IFID_VALID  out  1  IF/ID holds a real instruction
- HALTED  out  1  controller is in HALT
- FETCH_CNT  out  32  count of valid IF/ID loads; wraps

## Operation
- States: RUN, HALT. Reset enters RUN.
- Reset values:
  - PC = RESET_PC
  - IFID_INSTR = 0, IFID_PC = 0, IFID_VALID = 0
  - HALTED = 0
  - DBG_ACK = 0, DBG_DATA = 0
  - FETCH_CNT = 0
- IMA:
  - Equals DBG_ADDR when in HALT with DBG_REQ = 1.
  - Otherwise equals PC.
- RUN, per edge, priority RST > REDIR > FLUSH > STALL > advance:
  - REDIR: PC ← REDIR_PC; IFID_VALID ← 0.
  - FLUSH (no REDIR): IFID_VALID ← 0; PC holds, so the same word is refetched.
  - STALL (no REDIR/FLUSH): PC, IFID_* and FETCH_CNT all hold.
  - Advance: IFID_INSTR ← IMRD; IFID_PC ← PC; IFID_VALID ← 1; PC ← PC+1 mod 2^AWL; FETCH_CNT ← FETCH_CNT+1.
- HALT_REQ in RUN:
  - The PC update for that edge is applied first, per the priority above.
  - Then state ← HALT and IFID_VALID ← 0.
  - If STALL is also asserted, the halt is taken anyway; PC holds.
- HALT:
  - PC and FETCH_CNT frozen; IFID_VALID stays 0; HALTED = 1.
  - STALL, FLUSH and REDIR are ignored.
  - DBG_REQ = 1 at an edge: DBG_DATA ← IMRD at DBG_ADDR; DBG_ACK = 1 for the following cycle.
  - Back-to-back DBG_REQ gives one ACK per cycle.
- RESUME in HALT: state ← RUN at the edge.
  - A DBG_REQ in the same cycle is still served.
  - Fetch restarts at the held PC.
- HALT_REQ and RESUME together: in RUN, halt wins; in HALT, resume wins.
- DBG_REQ in RUN: ignored; DBG_ACK stays 0.
- PC wrap: PC = 2^AWL−1 advances to 0 with no flag.
- FETCH_CNT wraps from 2^32−1 to 0.

## Timing
- Fetch latency: instruction at PC appears on IFID_INSTR one edge after IMA = PC.
- Redirect: the first target instruction becomes valid at the second edge after REDIR is sampled. Exactly one bubble.
- Halt entry: HALTED = 1 the cycle after HALT_REQ is sampled.
- Debug read: DBG_DATA/DBG_ACK the cycle after DBG_REQ is sampled.
- Resume: the first valid IF/ID is at the second edge after RESUME is sampled (resume edge, then first fetch edge).
- RST mid-halt or mid-debug read: everything returns to reset values the next edge; a pending DBG_ACK is dropped.

## Structure
- Package imem_fetch_pkg holds:
  - state enum {RUN, HALT}
  - the default RESET_PC constant
- One natural sub-module, ifid_reg: the IF/ID register with load / hold / squash controls and its reset values.
- imem_fetch_ctrl instantiates ifid_reg and connects to InstMem through IMA/IMRD.

## Test plan
- Reset, then 4 free-running cycles with RESET_PC = 0 and rom[i] = i+0x100 → IFID sequence 0x100..0x103, IFID_PC 0..3, FETCH_CNT = 4.
- STALL for 2 cycles at PC = 3, then REDIR_PC = 20 with STALL also high → IF/ID held during the stall. The REDIR edge gives IFID_VALID = 0; the next edge gives IFID_INSTR = rom[20], IFID_PC = 20.
- FLUSH alone at PC = 5 → IFID_VALID = 0 for one cycle; the next edge gives IFID_PC = 5 (refetch).
- HALT_REQ at PC = 7, then DBG_REQ at addresses 2, 30, 31 back-to-back, then RESUME:
  - HALTED = 1.
  - DBG_DATA = rom[2], rom[30], rom[31] on three consecutive ACK pulses.
  - After resume, the first valid IFID_PC = 7.
- PC = 31 advancing → IFID_PC = 31, then 0.
- DBG_REQ while running gives no ACK. RST asserted in HALT → HALTED = 0, PC = RESET_PC, FETCH_CNT = 0.
